// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX byte FIFOs. CPOL/CPHA/bit order and the SCK half-period
// (SPPR+1) << SPR system clocks are sampled when a frame loads and held until it ends.
module spi_master_fifo #(
   parameter int DataWidth      = 8,
   parameter int FIFOWriteDepth = 4,
   parameter int FIFOReadDepth  = 4,
   parameter int SPPRWidth      = 4,
   parameter int SPRWidth       = 4
) (
   input  logic                 Clk_i,
   input  logic                 Reset_n_i,
   input  logic                 CPOL_i,
   input  logic                 CPHA_i,
   input  logic                 LSBFE_i,
   input  logic [SPPRWidth-1:0] SPPR_i,
   input  logic [SPRWidth-1:0]  SPR_i,
   input  logic                 Write_i,
   input  logic [DataWidth-1:0] Data_i,
   input  logic                 ReadNext_i,
   output logic [DataWidth-1:0] Data_o,
   output logic                 FIFOFull_o,
   output logic                 FIFOEmpty_o,
   output logic                 Transmission_o,
   output logic                 SCK_o,
   output logic                 MOSI_o,
   input  logic                 MISO_i
);

   localparam int TxAw      = $clog2(FIFOWriteDepth);
   localparam int RxAw      = $clog2(FIFOReadDepth);
   localparam int TxCw      = TxAw + 1;
   localparam int RxCw      = RxAw + 1;
   localparam int DivWidth  = SPPRWidth + (1 << SPRWidth);
   localparam int EdgeWidth = $clog2(2 * DataWidth + 1);

   localparam logic [TxAw-1:0]      TxPtrOne  = TxAw'(1);
   localparam logic [RxAw-1:0]      RxPtrOne  = RxAw'(1);
   localparam logic [TxCw-1:0]      TxCntOne  = TxCw'(1);
   localparam logic [RxCw-1:0]      RxCntOne  = RxCw'(1);
   localparam logic [TxCw-1:0]      TxFullCnt = TxCw'(FIFOWriteDepth);
   localparam logic [RxCw-1:0]      RxFullCnt = RxCw'(FIFOReadDepth);
   localparam logic [DivWidth-1:0]  DivOne    = DivWidth'(1);
   localparam logic [EdgeWidth-1:0] EdgeOne   = EdgeWidth'(1);
   localparam logic [EdgeWidth-1:0] LastEdge  = EdgeWidth'(2 * DataWidth);

   typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

   state_t               state_reg;

   logic [DataWidth-1:0] tx_mem [FIFOWriteDepth];
   logic [TxAw-1:0]      tx_wr_ptr_reg, tx_rd_ptr_reg;
   logic [TxCw-1:0]      tx_count_reg, tx_count_next;
   logic                 tx_full, tx_empty, tx_push;
   logic [DataWidth-1:0] tx_head;

   logic [DataWidth-1:0] rx_mem [FIFOReadDepth];
   logic [RxAw-1:0]      rx_wr_ptr_reg, rx_rd_ptr_reg, rx_rd_ptr_next;
   logic [RxCw-1:0]      rx_count_reg, rx_count_next;
   logic                 rx_full, rx_empty, rx_push, rx_pop;
   logic [DataWidth-1:0] rx_push_data, data_o_reg;

   logic                 cpol_reg, cpha_reg, lsbfe_reg;
   logic                 sck_reg, mosi_reg, xfer_reg;
   logic [DivWidth-1:0]  half_period, div_reload_reg, div_cnt_reg;
   logic [EdgeWidth-1:0] edge_cnt_reg, edge_num;
   logic [DataWidth-1:0] tx_shift_reg, rx_shift_reg, rx_shift_next;
   logic                 tick, last_edge, sample_now, shift_now, load;

   function automatic logic lead_bit(input logic [DataWidth-1:0] d, input logic lsb_first);
      return lsb_first ? d[0] : d[DataWidth-1];
   endfunction

   function automatic logic [DataWidth-1:0] shift_out(input logic [DataWidth-1:0] d,
                                                      input logic lsb_first);
      return lsb_first ? {1'b0, d[DataWidth-1:1]} : {d[DataWidth-2:0], 1'b0};
   endfunction

   // ---------------- TX FIFO ----------------
   assign tx_full  = (tx_count_reg == TxFullCnt);
   assign tx_empty = (tx_count_reg == '0);
   assign tx_push  = Write_i && !tx_full;
   assign tx_head  = tx_mem[tx_rd_ptr_reg];

   always_comb begin
      tx_count_next = tx_count_reg;
      if (tx_push && !load)
         tx_count_next = tx_count_reg + TxCntOne;
      else if (!tx_push && load)
         tx_count_next = tx_count_reg - TxCntOne;
   end

   always_ff @(posedge Clk_i) begin
      if (tx_push)
         tx_mem[tx_wr_ptr_reg] <= Data_i;
   end

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         tx_wr_ptr_reg <= '0;
         tx_rd_ptr_reg <= '0;
         tx_count_reg  <= '0;
      end else begin
         if (tx_push)
            tx_wr_ptr_reg <= tx_wr_ptr_reg + TxPtrOne;
         if (load)
            tx_rd_ptr_reg <= tx_rd_ptr_reg + TxPtrOne;
         tx_count_reg <= tx_count_next;
      end
   end

   // ---------------- RX FIFO ----------------
   assign rx_full        = (rx_count_reg == RxFullCnt);
   assign rx_empty       = (rx_count_reg == '0);
   assign rx_pop         = ReadNext_i && !rx_empty;
   assign rx_rd_ptr_next = rx_pop ? rx_rd_ptr_reg + RxPtrOne : rx_rd_ptr_reg;
   assign rx_push        = last_edge;
   assign rx_push_data   = sample_now ? rx_shift_next : rx_shift_reg;

   always_comb begin
      rx_count_next = rx_count_reg;
      if (rx_push && !rx_pop)
         rx_count_next = rx_count_reg + RxCntOne;
      else if (!rx_push && rx_pop)
         rx_count_next = rx_count_reg - RxCntOne;
   end

   always_ff @(posedge Clk_i) begin
      if (rx_push)
         rx_mem[rx_wr_ptr_reg] <= rx_push_data;
   end

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         rx_wr_ptr_reg <= '0;
         rx_rd_ptr_reg <= '0;
         rx_count_reg  <= '0;
         data_o_reg    <= '0;
      end else begin
         if (rx_push)
            rx_wr_ptr_reg <= rx_wr_ptr_reg + RxPtrOne;
         rx_rd_ptr_reg <= rx_rd_ptr_next;
         rx_count_reg  <= rx_count_next;
         // Head register: bypass the byte being written when it becomes the head;
         // a pop that empties the FIFO leaves the last value in place.
         if (rx_push && (rx_wr_ptr_reg == rx_rd_ptr_next))
            data_o_reg <= rx_push_data;
         else if (rx_push || (rx_pop && (rx_count_reg != RxCntOne)))
            data_o_reg <= rx_mem[rx_rd_ptr_next];
      end
   end

   // ---------------- Frame engine ----------------
   assign half_period   = (DivWidth'(SPPR_i) + DivOne) << SPR_i;
   assign tick          = (state_reg == ST_XFER) && (div_cnt_reg == '0);
   assign edge_num      = edge_cnt_reg + EdgeOne;
   assign last_edge     = tick && (edge_num == LastEdge);
   assign sample_now    = tick && (edge_num[0] != cpha_reg);
   assign shift_now     = tick && (edge_num[0] == cpha_reg) && !last_edge;
   assign rx_shift_next = lsbfe_reg ? {MISO_i, rx_shift_reg[DataWidth-1:1]}
                                    : {rx_shift_reg[DataWidth-2:0], MISO_i};

   // Idle starts use the registered RX count so a freeing pop starts the frame one
   // cycle later; at frame end the count after this edge's push/pop decides chaining.
   assign load = !tx_empty && (((state_reg == ST_IDLE) && !rx_full) ||
                               (last_edge && (rx_count_next != RxFullCnt)));

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         state_reg      <= ST_IDLE;
         xfer_reg       <= 1'b0;
         cpol_reg       <= 1'b0;
         cpha_reg       <= 1'b0;
         lsbfe_reg      <= 1'b0;
         div_reload_reg <= '0;
         div_cnt_reg    <= '0;
         edge_cnt_reg   <= '0;
         sck_reg        <= 1'b0;
         mosi_reg       <= 1'b1;
         tx_shift_reg   <= '0;
         rx_shift_reg   <= '0;
      end else if (load) begin
         state_reg      <= ST_XFER;
         xfer_reg       <= 1'b1;
         cpol_reg       <= CPOL_i;
         cpha_reg       <= CPHA_i;
         lsbfe_reg      <= LSBFE_i;
         div_reload_reg <= half_period - DivOne;
         div_cnt_reg    <= half_period - DivOne;
         edge_cnt_reg   <= '0;
         sck_reg        <= CPOL_i;
         rx_shift_reg   <= '0;
         if (CPHA_i) begin
            tx_shift_reg <= tx_head;
         end else begin
            mosi_reg     <= lead_bit(tx_head, LSBFE_i);
            tx_shift_reg <= shift_out(tx_head, LSBFE_i);
         end
      end else if (tick) begin
         div_cnt_reg <= div_reload_reg;
         sck_reg     <= ~sck_reg;
         if (last_edge) begin
            state_reg    <= ST_IDLE;
            xfer_reg     <= 1'b0;
            edge_cnt_reg <= '0;
         end else begin
            edge_cnt_reg <= edge_num;
         end
         if (shift_now) begin
            mosi_reg     <= lead_bit(tx_shift_reg, lsbfe_reg);
            tx_shift_reg <= shift_out(tx_shift_reg, lsbfe_reg);
         end
         if (sample_now)
            rx_shift_reg <= rx_shift_next;
      end else if (state_reg == ST_XFER) begin
         div_cnt_reg <= div_cnt_reg - DivOne;
      end
   end

   // While idle (and in reset) SCK follows the live CPOL input.
   assign SCK_o          = xfer_reg ? sck_reg : CPOL_i;
   assign MOSI_o         = mosi_reg;
   assign Transmission_o = xfer_reg;
   assign Data_o         = data_o_reg;
   assign FIFOFull_o     = tx_full;
   assign FIFOEmpty_o    = rx_empty;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: modes, rates, chaining, FIFO limits, reset abort.
module tb_spi_master_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cpol, cpha, lsbfe;
   logic [3:0] sppr, spr;
   logic       wr, rd_next;
   logic [7:0] wdata;
   logic [7:0] dout;
   logic       full, empty, trans, sck, mosi;
   logic       miso_drv, loopback;
   wire        miso = loopback ? mosi : miso_drv;

   int n_checks = 0;
   int n_pass   = 0;

   // activity monitor, sampled 2 time units after each rising edge
   logic mon_clr = 1'b1;
   int   hi_cnt, tog_cnt, drop_cnt;
   logic sck_prev, trans_prev;

   spi_master_fifo dut (
      .Clk_i          (clk),
      .Reset_n_i      (rst_n),
      .CPOL_i         (cpol),
      .CPHA_i         (cpha),
      .LSBFE_i        (lsbfe),
      .SPPR_i         (sppr),
      .SPR_i          (spr),
      .Write_i        (wr),
      .Data_i         (wdata),
      .ReadNext_i     (rd_next),
      .Data_o         (dout),
      .FIFOFull_o     (full),
      .FIFOEmpty_o    (empty),
      .Transmission_o (trans),
      .SCK_o          (sck),
      .MOSI_o         (mosi),
      .MISO_i         (miso)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      if (mon_clr) begin
         hi_cnt   = 0;
         tog_cnt  = 0;
         drop_cnt = 0;
      end else begin
         if (trans) hi_cnt++;
         if (sck !== sck_prev) tog_cnt++;
         if (trans_prev && !trans) drop_cnt++;
      end
      sck_prev   = sck;
      trans_prev = trans;
   end

   task automatic set_mode(input logic p, input logic h, input logic l,
                           input logic [3:0] pr, input logic [3:0] r);
      @(negedge clk);
      cpol = p; cpha = h; lsbfe = l; sppr = pr; spr = r;
      mon_clr = 1'b1;
      @(negedge clk);
      mon_clr = 1'b0;
   endtask

   task automatic pulse_read();
      rd_next = 1'b1;
      @(negedge clk);
      rd_next = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b0; sppr = 4'd0; spr = 4'd0;
      wr = 1'b0; wdata = 8'h00; rd_next = 1'b0; miso_drv = 1'b0; loopback = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
      n_checks++; if (dout !== 8'h00) $display("FAIL reset_data got %h want 00", dout); else n_pass++;
      n_checks++; if (trans !== 1'b0) $display("FAIL reset_trans got %b want 0", trans); else n_pass++;
      n_checks++; if (mosi !== 1'b1) $display("FAIL reset_mosi got %b want 1", mosi); else n_pass++;
      n_checks++; if (sck !== 1'b1) $display("FAIL reset_sck_cpol1 got %b want 1", sck); else n_pass++;
      cpol = 1'b0;
      #1;
      n_checks++; if (sck !== 1'b0) $display("FAIL reset_sck_cpol0 got %b want 0", sck); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_read();
      n_checks++; if (empty !== 1'b1) $display("FAIL read_empty_ignored got %b want 1", empty); else n_pass++;
      n_checks++; if (dout !== 8'h00) $display("FAIL read_empty_data got %h want 00", dout); else n_pass++;
      $display("test_reset: done");
   endtask

   task automatic test_mode3();
      logic [7:0] tx_b = 8'hA5;
      logic [7:0] rx_b = 8'h3C;
      set_mode(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      loopback = 1'b0;
      wr = 1'b1; wdata = tx_b;
      @(negedge clk);
      wr = 1'b0;
      n_checks++; if (trans !== 1'b0) $display("FAIL m3_trans_before_load got %b want 0", trans); else n_pass++;
      @(negedge clk);
      n_checks++; if (trans !== 1'b1) $display("FAIL m3_trans_load got %b want 1", trans); else n_pass++;
      n_checks++; if (sck !== 1'b1) $display("FAIL m3_sck_load got %b want 1", sck); else n_pass++;
      for (int e = 1; e <= 16; e++) begin
         if (e % 2 == 0) miso_drv = rx_b[8 - e / 2];
         @(negedge clk);
         n_checks++;
         if (sck !== ((e % 2 == 1) ? 1'b0 : 1'b1))
            $display("FAIL m3_sck edge=%0d got %b", e, sck);
         else n_pass++;
         if (e % 2 == 1) begin
            n_checks++;
            if (mosi !== tx_b[7 - (e - 1) / 2])
               $display("FAIL m3_mosi edge=%0d got %b want %b", e, mosi, tx_b[7 - (e - 1) / 2]);
            else n_pass++;
         end
      end
      n_checks++; if (trans !== 1'b0) $display("FAIL m3_trans_end got %b want 0", trans); else n_pass++;
      repeat (2) @(negedge clk);
      n_checks++; if (hi_cnt !== 16) $display("FAIL m3_trans_cycles got %0d want 16", hi_cnt); else n_pass++;
      n_checks++; if (tog_cnt !== 16) $display("FAIL m3_sck_toggles got %0d want 16", tog_cnt); else n_pass++;
      n_checks++; if (dout !== 8'h3C) $display("FAIL m3_rx_data got %h want 3c", dout); else n_pass++;
      n_checks++; if (empty !== 1'b0) $display("FAIL m3_rx_empty got %b want 0", empty); else n_pass++;
      pulse_read();
      n_checks++; if (empty !== 1'b1) $display("FAIL m3_rx_drained got %b want 1", empty); else n_pass++;
      $display("test_mode3: sent a5, received %h", 8'h3C);
   endtask

   task automatic test_mode0_slow();
      int c, first_t, second_t, end_c;
      logic prev;
      set_mode(1'b0, 1'b0, 1'b1, 4'd2, 4'd1);
      loopback = 1'b1;
      wr = 1'b1; wdata = 8'h01;
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
      n_checks++; if (mosi !== 1'b1) $display("FAIL m0_mosi_load got %b want 1", mosi); else n_pass++;
      n_checks++; if (trans !== 1'b1) $display("FAIL m0_trans_load got %b want 1", trans); else n_pass++;
      c = 0; first_t = -1; second_t = -1; end_c = -1; prev = sck;
      while (end_c < 0 && c < 300) begin
         @(negedge clk);
         c++;
         if (sck !== prev) begin
            if (first_t < 0) first_t = c;
            else if (second_t < 0) second_t = c;
         end
         prev = sck;
         if (c == 12) begin
            n_checks++; if (mosi !== 1'b0) $display("FAIL m0_mosi_bit1 got %b want 0", mosi); else n_pass++;
         end
         if (!trans) end_c = c;
      end
      n_checks++; if (first_t !== 6) $display("FAIL m0_edge1_cycle got %0d want 6", first_t); else n_pass++;
      n_checks++; if (second_t !== 12) $display("FAIL m0_edge2_cycle got %0d want 12", second_t); else n_pass++;
      n_checks++; if (end_c !== 96) $display("FAIL m0_frame_len got %0d want 96", end_c); else n_pass++;
      @(negedge clk);
      n_checks++; if (hi_cnt !== 96) $display("FAIL m0_trans_cycles got %0d want 96", hi_cnt); else n_pass++;
      n_checks++; if (sck !== 1'b0) $display("FAIL m0_sck_idle got %b want 0", sck); else n_pass++;
      n_checks++; if (dout !== 8'h01) $display("FAIL m0_rx_data got %h want 01", dout); else n_pass++;
      pulse_read();
      $display("test_mode0_slow: frame of %0d cycles", end_c);
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q [3] = '{8'h11, 8'h22, 8'h33};
      set_mode(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      loopback = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr = 1'b1; wdata = exp_q[i];
         @(negedge clk);
      end
      wr = 1'b0;
      for (int k = 0; k < 200 && drop_cnt < 1; k++) @(negedge clk);
      n_checks++; if (drop_cnt !== 1) $display("FAIL b2b_end got drops=%0d want 1", drop_cnt); else n_pass++;
      n_checks++; if (hi_cnt !== 48) $display("FAIL b2b_trans_cycles got %0d want 48", hi_cnt); else n_pass++;
      n_checks++; if (tog_cnt !== 48) $display("FAIL b2b_sck_toggles got %0d want 48", tog_cnt); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (dout !== exp_q[i]) $display("FAIL b2b_rx%0d got %h want %h", i, dout, exp_q[i]);
         else n_pass++;
         pulse_read();
      end
      n_checks++; if (empty !== 1'b1) $display("FAIL b2b_rx_empty got %b want 1", empty); else n_pass++;
      $display("test_back_to_back: 3 frames chained");
   endtask

   task automatic test_full_stall();
      set_mode(1'b0, 1'b1, 1'b0, 4'd3, 4'd0);
      loopback = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) begin
            n_checks++; if (full !== 1'b0) $display("FAIL fs_full_after4 got %b want 0", full); else n_pass++;
         end
         if (i == 5) begin
            n_checks++; if (full !== 1'b1) $display("FAIL fs_full_after5 got %b want 1", full); else n_pass++;
         end
         wr = 1'b1; wdata = 8'hC1 + 8'(i);
         @(negedge clk);
      end
      wr = 1'b0;
      n_checks++; if (full !== 1'b1) $display("FAIL fs_full_after6 got %b want 1", full); else n_pass++;
      for (int k = 0; k < 600 && drop_cnt < 1; k++) @(negedge clk);
      n_checks++; if (drop_cnt !== 1) $display("FAIL fs_stall got drops=%0d want 1", drop_cnt); else n_pass++;
      n_checks++; if (hi_cnt !== 256) $display("FAIL fs_trans_cycles got %0d want 256", hi_cnt); else n_pass++;
      n_checks++; if (tog_cnt !== 64) $display("FAIL fs_sck_toggles got %0d want 64", tog_cnt); else n_pass++;
      n_checks++; if (full !== 1'b0) $display("FAIL fs_full_stalled got %b want 0", full); else n_pass++;
      n_checks++; if (dout !== 8'hC1) $display("FAIL fs_head got %h want c1", dout); else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++; if (trans !== 1'b0) $display("FAIL fs_still_stalled got %b want 0", trans); else n_pass++;
      n_checks++; if (sck !== 1'b0) $display("FAIL fs_sck_idle got %b want 0", sck); else n_pass++;
      pulse_read();
      n_checks++; if (trans !== 1'b0) $display("FAIL fs_trans_at_pop got %b want 0", trans); else n_pass++;
      @(negedge clk);
      n_checks++; if (trans !== 1'b1) $display("FAIL fs_restart got %b want 1", trans); else n_pass++;
      for (int k = 0; k < 200 && drop_cnt < 2; k++) @(negedge clk);
      n_checks++; if (drop_cnt !== 2) $display("FAIL fs_frame5 got drops=%0d want 2", drop_cnt); else n_pass++;
      for (int i = 1; i < 5; i++) begin
         n_checks++;
         if (dout !== 8'hC1 + 8'(i)) $display("FAIL fs_rx%0d got %h want %h", i, dout, 8'hC1 + 8'(i));
         else n_pass++;
         pulse_read();
      end
      repeat (10) @(negedge clk);
      n_checks++; if (trans !== 1'b0 || drop_cnt !== 2)
         $display("FAIL fs_sixth_dropped got trans=%b drops=%0d want 0/2", trans, drop_cnt);
      else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL fs_rx_empty got %b want 1", empty); else n_pass++;
      $display("test_full_stall: 5 frames, 6th byte dropped");
   endtask

   task automatic test_reset_midframe();
      set_mode(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      loopback = 1'b1;
      wr = 1'b1; wdata = 8'h5A;
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
      repeat (7) @(negedge clk);
      n_checks++; if (sck !== 1'b1) $display("FAIL rst_sck_edge7 got %b want 1", sck); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (sck !== 1'b0) $display("FAIL rst_sck got %b want 0", sck); else n_pass++;
      n_checks++; if (trans !== 1'b0) $display("FAIL rst_trans got %b want 0", trans); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty got %b want 1", empty); else n_pass++;
      n_checks++; if (dout !== 8'h00) $display("FAIL rst_data got %h want 00", dout); else n_pass++;
      n_checks++; if (mosi !== 1'b1) $display("FAIL rst_mosi got %b want 1", mosi); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++; if (empty !== 1'b1 || trans !== 1'b0)
         $display("FAIL rst_no_rx got empty=%b trans=%b want 1/0", empty, trans);
      else n_pass++;
      set_mode(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      wr = 1'b1; wdata = 8'h96;
      @(negedge clk);
      wr = 1'b0;
      for (int k = 0; k < 100 && drop_cnt < 1; k++) @(negedge clk);
      n_checks++; if (drop_cnt !== 1) $display("FAIL rst_fresh_done got drops=%0d want 1", drop_cnt); else n_pass++;
      n_checks++; if (dout !== 8'h96) $display("FAIL rst_fresh_data got %h want 96", dout); else n_pass++;
      $display("test_reset_midframe: abort and recovery");
   endtask

   initial begin
      test_reset();
      test_mode3();
      test_mode0_slow();
      test_back_to_back();
      test_full_stall();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
